// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter for four bus sources feeding a 4:1 mux select.
// Ownership holds until release, or until the hold limit expires while others wait.
module bus_source_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic       busy_q, busy_d;
    logic       preempt_q, preempt_d;

    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    logic       hold_hit;
    logic [3:0] others;

    always_comb begin
        pick  = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        // Search upward from last+1; offset 4 wraps back to last, giving it lowest priority.
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Compared as >= so a requester arriving after the limit is still honoured.
    assign hold_hit = (MAX_HOLD > 0) && (int'(hold_q) >= MAX_HOLD - 1);
    assign others   = req & ~grant_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick;
                    sel_d   = pick;
                    busy_d  = 1'b1;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    last_d  = sel_q;
                end else if (hold_hit && others != 4'b0000) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    busy_d    = 1'b0;
                    last_d    = sel_q;
                    preempt_d = 1'b1;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            hold_q    <= 8'd0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter: vector table, directed corner sequences and
// random traffic against a rule-level model, on MAX_HOLD=8 and MAX_HOLD=0 instances.
module tb_bus_source_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req8, req0;
    logic [3:0] grant8, grant0;
    logic [1:0] sel8, sel0;
    logic       busy8, busy0, pre8, pre0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_source_arbiter #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req8),
        .grant(grant8), .sel(sel8), .busy(busy8), .preempt(pre8)
    );

    bus_source_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0),
        .grant(grant0), .sel(sel0), .busy(busy0), .preempt(pre0)
    );

    typedef struct {
        bit busy;
        int owner;
        int last;
        int held;
        int sel;
        bit pre;
    } mdl_t;

    mdl_t m[2];
    int   mh[2] = '{8, 0};

    typedef struct {
        bit       r;
        bit [3:0] rq;
        bit [3:0] g;
        bit [1:0] s;
        bit       b;
        bit       p;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Rule-level model: owner index plus an unbounded count of cycles held.
    task automatic mstep(input int k, input bit r, input bit [3:0] rq);
        bit [3:0] mask;
        int       c;
        bit       fnd;
        m[k].pre = 1'b0;
        if (r) begin
            m[k].busy = 0; m[k].last = 3; m[k].held = 0; m[k].sel = 0; m[k].owner = 0;
        end else if (!m[k].busy) begin
            fnd = 0;
            for (int j = 1; j <= 4; j++) begin
                c = (m[k].last + j) % 4;
                if (!fnd && rq[c]) begin
                    m[k].owner = c;
                    fnd = 1;
                end
            end
            if (fnd) begin
                m[k].busy = 1; m[k].held = 0; m[k].sel = m[k].owner;
            end
        end else begin
            mask = rq;
            mask[m[k].owner] = 1'b0;
            if (!rq[m[k].owner]) begin
                m[k].busy = 0; m[k].last = m[k].owner;
            end else if (mh[k] > 0 && m[k].held >= mh[k] - 1 && mask != 4'b0000) begin
                m[k].busy = 0; m[k].last = m[k].owner; m[k].pre = 1;
            end else begin
                m[k].held++;
            end
        end
    endtask

    function automatic int mgrant(input int k);
        return m[k].busy ? (1 << m[k].owner) : 0;
    endfunction

    task automatic step(input bit r, input bit [3:0] a, input bit [3:0] b);
        rst  = r;
        req8 = a;
        req0 = b;
        @(posedge clk);
        #1;
        mstep(0, r, a);
        mstep(1, r, b);
        chk("m8_grant", int'(grant8), mgrant(0));
        chk("m8_sel", int'(sel8), m[0].sel);
        chk("m8_busy", int'(busy8), int'(m[0].busy));
        chk("m8_preempt", int'(pre8), int'(m[0].pre));
        chk("m0_grant", int'(grant0), mgrant(1));
        chk("m0_sel", int'(sel0), m[1].sel);
        chk("m0_busy", int'(busy0), int'(m[1].busy));
        chk("m0_preempt", int'(pre0), int'(m[1].pre));
    endtask

    initial begin
        vec_t vt[$];
        int   n;
        int   errs;
        bit [3:0] rq;

        rst = 1'b1; req8 = 4'b0; req0 = 4'b0;

        // r, req, grant, sel, busy, preempt  (expected values for the MAX_HOLD=8 instance)
        vt.push_back('{1, 4'b0000, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{0, 4'b0001, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{0, 4'b0001, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{0, 4'b0001, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{0, 4'b0000, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{1, 4'b0000, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{0, 4'b1111, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{0, 4'b1111, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{0, 4'b1110, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{0, 4'b1110, 4'b0010, 2'd1, 1, 0});
        vt.push_back('{0, 4'b1110, 4'b0010, 2'd1, 1, 0});
        vt.push_back('{0, 4'b1100, 4'b0000, 2'd1, 0, 0});
        vt.push_back('{0, 4'b1100, 4'b0100, 2'd2, 1, 0});
        vt.push_back('{0, 4'b1100, 4'b0100, 2'd2, 1, 0});
        vt.push_back('{0, 4'b1000, 4'b0000, 2'd2, 0, 0});
        vt.push_back('{0, 4'b1000, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{0, 4'b1000, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{0, 4'b0001, 4'b0000, 2'd3, 0, 0});
        vt.push_back('{0, 4'b0001, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{1, 4'b0000, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{0, 4'b1000, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{1, 4'b1001, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{0, 4'b1001, 4'b0001, 2'd0, 1, 0});

        foreach (vt[i]) begin
            step(vt[i].r, vt[i].rq, vt[i].rq);
            chk($sformatf("vec%0d_grant", i), int'(grant8), int'(vt[i].g));
            chk($sformatf("vec%0d_sel", i), int'(sel8), int'(vt[i].s));
            chk($sformatf("vec%0d_busy", i), int'(busy8), int'(vt[i].b));
            chk($sformatf("vec%0d_preempt", i), int'(pre8), int'(vt[i].p));
        end

        // Hold limit: owner 2 revoked after exactly 8 grant cycles once source 0 waits.
        step(1, 4'b0000, 4'b0000);
        step(0, 4'b0100, 4'b0000);
        n = (grant8 == 4'b0100) ? 1 : 0;
        step(0, 4'b0100, 4'b0000); if (grant8 == 4'b0100) n++;
        step(0, 4'b0100, 4'b0000); if (grant8 == 4'b0100) n++;
        for (int i = 0; i < 20; i++) begin
            step(0, 4'b0101, 4'b0000);
            if (grant8 == 4'b0100) n++;
            else break;
        end
        chk("hold_cycles", n, 8);
        chk("hold_preempt", int'(pre8), 1);
        chk("hold_idle", int'(grant8), 0);
        step(0, 4'b0101, 4'b0000);
        chk("after_pre_grant", int'(grant8), 4'b0001);
        chk("after_pre_sel", int'(sel8), 0);
        chk("after_pre_pulse", int'(pre8), 0);

        // Lone requester past saturation keeps the grant, no preempt.
        step(1, 4'b0000, 4'b0000);
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, 4'b0010, 4'b0000);
            if (i > 0 && (grant8 != 4'b0010 || pre8)) errs++;
        end
        chk("sat_lone_errs", errs, 0);
        step(0, 4'b0011, 4'b0000);
        chk("sat_late_req_preempt", int'(pre8), 1);

        // MAX_HOLD=0 never pre-empts.
        step(1, 4'b0000, 4'b0000);
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 4'b0000, 4'b0011);
            if (grant0 != 4'b0001 || pre0) errs++;
        end
        chk("nohold_errs", errs, 0);
        step(0, 4'b0000, 4'b0010);
        chk("nohold_idle", int'(grant0), 0);
        step(0, 4'b0000, 4'b0010);
        chk("nohold_next", int'(grant0), 4'b0010);
        chk("nohold_sel", int'(sel0), 1);

        // Random traffic: slowly toggling request bits, occasional reset.
        step(1, 4'b0000, 4'b0000);
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, 3)] ^= 1'b1;
            step(($urandom_range(0, 199) == 0), rq, rq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
